// File: rtl/tlb_cp0_ctrl.sv
// +--------------------------------------------------------------------+
// | tlb_cp0_ctrl : CP0 TLB register file and TLBR/TLBWI/TLBWR/TLBP     |
// | sequencer.  Revision: 1.0                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tlb_cp0_ctrl #(
   parameter int TLB_NUM = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         op_valid_i,
   input  logic [1:0]   op_type_i,
   output logic         op_ready_o,
   output logic         op_done_o,
   input  logic         mtc0_we_i,
   input  logic [4:0]   mtc0_addr_i,
   input  logic [31:0]  mtc0_wdata_i,
   input  logic [4:0]   mfc0_addr_i,
   output logic [31:0]  mfc0_rdata_o,
   output logic         tlb_write_index_o,
   output logic         tlb_write_random_o,
   output logic [191:0] cp0_tlb_bus_o,
   input  logic [159:0] tlb_cp0_bus_i
);

   localparam int c_IW = $clog2(TLB_NUM);
   localparam logic [c_IW-1:0] c_RAND_MAX = c_IW'(TLB_NUM - 1);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_EXEC = 2'd1;
   localparam logic [1:0] c_S_DONE = 2'd2;

   localparam logic [1:0] c_OP_TLBR  = 2'b00;
   localparam logic [1:0] c_OP_TLBWI = 2'b01;
   localparam logic [1:0] c_OP_TLBWR = 2'b10;
   localparam logic [1:0] c_OP_TLBP  = 2'b11;

   logic [1:0]      r_state;
   logic [1:0]      r_op;
   logic            r_index_p;
   logic [c_IW-1:0] r_index_idx;
   logic [c_IW-1:0] r_random;
   logic [c_IW-1:0] r_wired;
   logic [25:0]     r_entrylo0;
   logic [25:0]     r_entrylo1;
   logic [18:0]     r_vpn2;
   logic [7:0]      r_asid;

   logic            w_idle;
   logic            w_accept;
   logic            w_mtc0;
   logic            w_wired_wr;
   logic            w_exec_tlbr;
   logic            w_exec_tlbp;
   logic [c_IW-1:0] w_random_next;
   logic [31:0]     w_index_reg;
   logic [31:0]     w_random_reg;
   logic [31:0]     w_entrylo0_reg;
   logic [31:0]     w_entrylo1_reg;
   logic [31:0]     w_entryhi_reg;
   logic [31:0]     w_wired_reg;
   logic            w_unused;

   assign w_idle      = (r_state == c_S_IDLE);
   assign w_accept    = op_valid_i & w_idle;
   assign w_mtc0      = mtc0_we_i & w_idle;
   assign w_wired_wr  = w_mtc0 & (mtc0_addr_i == 5'd6);
   assign w_exec_tlbr = (r_state == c_S_EXEC) & (r_op == c_OP_TLBR);
   assign w_exec_tlbp = (r_state == c_S_EXEC) & (r_op == c_OP_TLBP);

   // Random counts down towards Wired, then wraps to the top entry.
   assign w_random_next = ((r_random == r_wired) || (r_wired == c_RAND_MAX))
                          ? c_RAND_MAX : (r_random - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_S_IDLE;
         r_op    <= c_OP_TLBR;
      end else begin
         case (r_state)
            c_S_IDLE: begin
               if (w_accept) begin
                  r_state <= c_S_EXEC;
                  r_op    <= op_type_i;
               end
            end
            c_S_EXEC: r_state <= c_S_DONE;
            default:  r_state <= c_S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_random <= c_RAND_MAX;
         r_wired  <= '0;
      end else if (w_wired_wr) begin
         r_wired  <= mtc0_wdata_i[c_IW-1:0];
         r_random <= c_RAND_MAX;
      end else if (w_idle && !w_accept) begin
         r_random <= w_random_next;
      end
   end

   // MTC0 is only honoured in IDLE, so it can never collide with an EXEC capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_index_p   <= 1'b0;
         r_index_idx <= '0;
         r_entrylo0  <= '0;
         r_entrylo1  <= '0;
         r_vpn2      <= '0;
         r_asid      <= '0;
      end else if (w_mtc0) begin
         case (mtc0_addr_i)
            5'd0:  r_index_idx <= mtc0_wdata_i[c_IW-1:0];
            5'd2:  r_entrylo0  <= mtc0_wdata_i[25:0];
            5'd3:  r_entrylo1  <= mtc0_wdata_i[25:0];
            5'd10: begin
               r_vpn2 <= mtc0_wdata_i[31:13];
               r_asid <= mtc0_wdata_i[7:0];
            end
            default: ;
         endcase
      end else if (w_exec_tlbr) begin
         r_vpn2     <= tlb_cp0_bus_i[95:77];
         r_asid     <= tlb_cp0_bus_i[71:64];
         r_entrylo0 <= tlb_cp0_bus_i[121:96];
         r_entrylo1 <= tlb_cp0_bus_i[153:128];
      end else if (w_exec_tlbp) begin
         r_index_p   <= tlb_cp0_bus_i[31];
         r_index_idx <= tlb_cp0_bus_i[c_IW-1:0];
      end
   end

   assign w_index_reg    = {r_index_p, {(31-c_IW){1'b0}}, r_index_idx};
   assign w_random_reg   = {{(32-c_IW){1'b0}}, r_random};
   assign w_wired_reg    = {{(32-c_IW){1'b0}}, r_wired};
   assign w_entrylo0_reg = {6'b0, r_entrylo0};
   assign w_entrylo1_reg = {6'b0, r_entrylo1};
   assign w_entryhi_reg  = {r_vpn2, 5'b0, r_asid};

   always_comb begin
      mfc0_rdata_o = 32'd0;
      case (mfc0_addr_i)
         5'd0:    mfc0_rdata_o = w_index_reg;
         5'd1:    mfc0_rdata_o = w_random_reg;
         5'd2:    mfc0_rdata_o = w_entrylo0_reg;
         5'd3:    mfc0_rdata_o = w_entrylo1_reg;
         5'd6:    mfc0_rdata_o = w_wired_reg;
         5'd10:   mfc0_rdata_o = w_entryhi_reg;
         default: mfc0_rdata_o = 32'd0;
      endcase
   end

   assign cp0_tlb_bus_o = {w_random_reg, w_entrylo1_reg, w_entrylo0_reg,
                           w_entryhi_reg, 32'd0, w_index_reg};

   assign op_ready_o         = w_idle;
   assign op_done_o          = (r_state == c_S_DONE);
   assign tlb_write_index_o  = (r_state == c_S_EXEC) & (r_op == c_OP_TLBWI);
   assign tlb_write_random_o = (r_state == c_S_EXEC) & (r_op == c_OP_TLBWR);

   // Returned-bus fields that have no writable home in this register set.
   assign w_unused = ^{tlb_cp0_bus_i[159:154], tlb_cp0_bus_i[127:122],
                       tlb_cp0_bus_i[76:72], tlb_cp0_bus_i[63:32],
                       tlb_cp0_bus_i[30:c_IW]};

endmodule

`default_nettype wire

// File: doc/tlb_cp0_ctrl.md
TLB_CP0_CTRL -- requirements
Module: tlb_cp0_ctrl

Interface
REQ-001 SHALL have parameter TLB_NUM, default 16, number of TLB entries (power of two, 2..64); IW = clog2(TLB_NUM).
REQ-002 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port op_valid_i  in  1  TLB instruction request.
REQ-005 SHALL have port op_type_i  in  2  encoding: 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP.
REQ-006 SHALL have port op_ready_o  out  1  controller can accept an op.
REQ-007 SHALL have port op_done_o  out  1  one-cycle op-completion pulse.
REQ-008 SHALL have port mtc0_we_i  in  1  CP0 register write strobe.
REQ-009 SHALL have port mtc0_addr_i  in  5  CP0 register number.
REQ-010 SHALL have port mtc0_wdata_i  in  32  write data.
REQ-011 SHALL have port mfc0_addr_i  in  5  read register number.
REQ-012 SHALL have port mfc0_rdata_o  out  32  combinational read data.
REQ-013 SHALL have port tlb_write_index_o  out  1  TLBWI write strobe to TLB.
REQ-014 SHALL have port tlb_write_random_o  out  1  TLBWR write strobe to TLB.
REQ-015 SHALL have port cp0_tlb_bus_o  out  192  {Random, EntryLo1, EntryLo0, EntryHi, PageMask, Index}, 32 bits each, Index at [31:0].
REQ-016 SHALL have port tlb_cp0_bus_i  in  160  {EntryLo1, EntryLo0, EntryHi, PageMask, ProbeIndex}, ProbeIndex at [31:0].

Function
REQ-017 SHALL hold registers: Index (reg 0: P bit31, idx [IW-1:0]), Random (reg 1, IW bits), EntryLo0 (reg 2, bits [25:0]), EntryLo1 (reg 3, bits [25:0]), PageMask (reg 5, constant 0), Wired (reg 6, IW bits), EntryHi (reg 10, VPN2 [31:13], ASID [7:0]); all unlisted bits read 0.
REQ-018 SHALL apply MTC0 only when state is IDLE; writes to regs 0,2,3,6,10 update writable bits; writes to Index leave P unchanged; writes to 1, 5 and others are ignored; MTC0 outside IDLE is dropped.
REQ-019 SHALL, on a Wired write, set Wired = wdata[IW-1:0] and Random = TLB_NUM-1 in the same edge.
REQ-020 SHALL decrement Random each IDLE cycle in which no op is accepted and no Wired write occurs; when Random == Wired (or Wired >= TLB_NUM-1) the next value is TLB_NUM-1 (wrap).
REQ-021 SHALL freeze Random in the accept cycle and in every non-IDLE cycle.
REQ-022 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; op_ready_o = (state == IDLE); accept = op_valid_i & op_ready_o; op_type latched on accept.
REQ-023 SHALL, in EXEC, assert tlb_write_index_o for TLBWI or tlb_write_random_o for TLBWR for exactly that one cycle; both are 0 in every other cycle.
REQ-024 SHALL, at the end of EXEC for TLBR, load EntryHi, EntryLo0 and EntryLo1 from tlb_cp0_bus_i (masked to writable bits); PageMask stays 0.
REQ-025 SHALL, at the end of EXEC for TLBP, load Index with ProbeIndex bit31 (P) and bits [IW-1:0].
REQ-026 SHALL assert op_done_o for the single DONE cycle; latency is accept at cycle N, strobe/capture at N+1, done at N+2; at most one op in flight.
REQ-027 SHALL, when MTC0 and accept coincide in IDLE, commit the MTC0 first so that EXEC drives the updated value on cp0_tlb_bus_o.
REQ-028 SHALL drive cp0_tlb_bus_o continuously from the current registers, zero-extended.
REQ-029 SHALL return mfc0_rdata_o as the register formatted per REQ-017, and 0 for unimplemented addresses.

Reset
REQ-030 SHALL, when rst is high at a clock edge, set state = IDLE; Index, EntryLo0, EntryLo1, EntryHi and Wired = 0; Random = TLB_NUM-1; strobes and op_done_o = 0.
REQ-031 SHALL, if rst is asserted mid-op, abandon the op with no strobe and no done pulse; op_ready_o = 1 in the first cycle after reset.

Verification (TLB_NUM=16)
REQ-032 SHALL cover reset then 3 idle cycles -> Random reads 15, 14, 13, then 12.
REQ-033 SHALL cover MTC0 Wired=14, then idle -> Random reads 15, 14, 15, 14 (wrap at Wired).
REQ-034 SHALL cover MTC0 Index=5, EntryHi=0x00402003, then TLBWI -> tlb_write_index_o high only at N+1, bus Index[3:0]=5, EntryHi=0x00402003, op_done_o at N+2.
REQ-035 SHALL cover TLBP with ProbeIndex=0x80000000 -> mfc0 reg 0 = 0x80000000; with ProbeIndex=0x00000007 -> mfc0 reg 0 = 0x00000007.
REQ-036 SHALL cover TLBR with the TLB returning EntryLo0=0xFFFFFFFF -> reg 2 reads 0x03FFFFFF and PageMask reads 0.
REQ-037 SHALL cover rst asserted during EXEC of TLBWR -> no done pulse, Random = 15, op_ready_o = 1 next cycle.
